// File: rtl/counter_pkg.sv
// Shared definitions for the counter family.
//   CNT_WRAP / CNT_SAT : bound behaviour selector for the SATURATE parameter
//   CNT_DOWN / CNT_UP  : up_dn encodings
//   clamp_to_max       : limits a load value to the terminal value
package counter_pkg;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  localparam bit CNT_DOWN = 1'b0;
  localparam bit CNT_UP   = 1'b1;

  // Operates on 32-bit values so that one function serves every counter width.
  function automatic logic [31:0] clamp_to_max(input logic [31:0] val,
                                               input logic [31:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: produces a step once every PRESCALE qualified enable cycles.
//   clk     : rising-edge clock
//   rst     : asynchronous active-low reset
//   restart : synchronous return of the prescale count to 0
//   enable  : count request for this cycle
//   step    : high on the enable cycle that completes a prescale period
module counter_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic enable,
  output logic step
);

  if (PRESCALE == 1) begin : g_bypass
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, restart};
    assign step          = enable;
  end else begin : g_div
    localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt <= '0;
      end else if (restart) begin
        cnt <= '0;
      end else if (enable) begin
        cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
      end
    end

    assign step = enable && (cnt == LAST);
  end

endmodule

// File: rtl/counter_mod_updn.sv
// Parametrised up/down modulo counter with clear, clamped load, wrap or
// saturate at the bounds, enable prescaler and terminal-count/wrap flags.
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   clr      : synchronous clear (highest priority), also restarts prescaler
//   load     : synchronous load of load_val (clamped to MAX_VAL), restarts prescaler
//   load_val : value to load
//   enable   : count request
//   up_dn    : 1 counts up, 0 counts down
//   Q        : registered count
//   tc       : combinational, a step this cycle would hit the bound in direction up_dn
//   wrap     : registered one-cycle pulse alongside a wrapped Q
//   zero     : combinational, Q == 0
module counter_mod_updn
  import counter_pkg::*;
#(
  parameter int N        = 8,
  parameter int MAX_VAL  = 2**N - 1,
  parameter int SATURATE = CNT_WRAP,
  parameter int PRESCALE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         enable,
  input  logic         up_dn,
  output logic [N-1:0] Q,
  output logic         tc,
  output logic         wrap,
  output logic         zero
);

  localparam logic [N-1:0] MAXV = N'(MAX_VAL);

  logic         step;
  logic         at_max;
  logic         at_zero;
  logic         at_bound;
  logic [N-1:0] load_clamped;
  logic [N-1:0] q_nxt;
  logic         wrap_nxt;

  counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .restart(clr | load),
    .enable (enable),
    .step   (step)
  );

  assign at_max       = (Q == MAXV);
  assign at_zero      = (Q == '0);
  assign at_bound     = (up_dn == CNT_UP) ? at_max : at_zero;
  assign load_clamped = N'(clamp_to_max(32'(load_val), 32'(MAXV)));

  // tc deliberately ignores clr/load: it reports the step request, not its outcome.
  assign tc   = step & at_bound;
  assign zero = at_zero;

  always_comb begin
    q_nxt    = Q;
    wrap_nxt = 1'b0;
    if (clr) begin
      q_nxt = '0;
    end else if (load) begin
      q_nxt = load_clamped;
    end else if (step) begin
      if (up_dn == CNT_UP) begin
        if (!at_max) begin
          q_nxt = Q + N'(1);
        end else if (SATURATE == CNT_WRAP) begin
          q_nxt    = '0;
          wrap_nxt = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          q_nxt = Q - N'(1);
        end else if (SATURATE == CNT_WRAP) begin
          q_nxt    = MAXV;
          wrap_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Q    <= '0;
      wrap <= 1'b0;
    end else begin
      Q    <= q_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_counter_mod_updn.sv
// Directed bench for counter_mod_updn: three instances (wrap, saturate,
// prescale-by-3) share stimulus; each scenario task checks its own instance.
module tb_counter_mod_updn;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr, load, enable, up_dn;
  logic [3:0] load_val;

  logic [3:0] q_w, q_s, q_p;
  logic       tc_w, tc_s, tc_p;
  logic       wrap_w, wrap_s, wrap_p;
  logic       zero_w, zero_s, zero_p;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_mod_updn #(.N(4), .MAX_VAL(9), .SATURATE(0), .PRESCALE(1)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .enable(enable), .up_dn(up_dn), .Q(q_w), .tc(tc_w), .wrap(wrap_w), .zero(zero_w));

  counter_mod_updn #(.N(4), .MAX_VAL(9), .SATURATE(1), .PRESCALE(1)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .enable(enable), .up_dn(up_dn), .Q(q_s), .tc(tc_s), .wrap(wrap_s), .zero(zero_s));

  counter_mod_updn #(.N(4), .MAX_VAL(9), .SATURATE(0), .PRESCALE(3)) u_pre (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .enable(enable), .up_dn(up_dn), .Q(q_p), .tc(tc_p), .wrap(wrap_p), .zero(zero_p));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (q_w !== 4'd0) begin errors++; $display("FAIL reset_q got %0d exp 0", q_w); end
    checks++; if (wrap_w !== 1'b0) begin errors++; $display("FAIL reset_wrap got %0b exp 0", wrap_w); end
    checks++; if (zero_w !== 1'b1) begin errors++; $display("FAIL reset_zero got %0b exp 1", zero_w); end
    checks++; if (zero_s !== 1'b1) begin errors++; $display("FAIL reset_zero_sat got %0b exp 1", zero_s); end
    checks++; if (tc_w !== 1'b0) begin errors++; $display("FAIL reset_tc_idle got %0b exp 0", tc_w); end
    enable = 1'b1; up_dn = 1'b0;
    #1;
    checks++; if (tc_w !== 1'b1) begin errors++; $display("FAIL reset_tc_down got %0b exp 1", tc_w); end
    checks++; if (tc_p !== 1'b0) begin errors++; $display("FAIL reset_tc_pre got %0b exp 0", tc_p); end
    tick();
    checks++; if (q_w !== 4'd0) begin errors++; $display("FAIL reset_hold_q got %0d exp 0", q_w); end
    enable = 1'b0; up_dn = 1'b1;
    rst = 1'b1;
    tick();
    checks++; if (q_w !== 4'd0) begin errors++; $display("FAIL reset_release_q got %0d exp 0", q_w); end
  endtask

  task automatic test_up_wrap();
    int     exp_q  [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    logic   exp_tc [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    logic   exp_wr [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    enable = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      checks++; if (tc_w !== exp_tc[i]) begin errors++; $display("FAIL up_wrap_tc[%0d] got %0b exp %0b", i, tc_w, exp_tc[i]); end
      tick();
      checks++; if (q_w !== 4'(exp_q[i])) begin errors++; $display("FAIL up_wrap_q[%0d] got %0d exp %0d", i, q_w, exp_q[i]); end
      checks++; if (wrap_w !== exp_wr[i]) begin errors++; $display("FAIL up_wrap_wrap[%0d] got %0b exp %0b", i, wrap_w, exp_wr[i]); end
    end
    enable = 1'b0;
  endtask

  task automatic test_down_sat();
    int   exp_q  [4] = '{1, 0, 0, 0};
    logic exp_tc [4] = '{0, 0, 1, 1};
    load = 1'b1; load_val = 4'd2;
    tick();
    load = 1'b0;
    checks++; if (q_s !== 4'd2) begin errors++; $display("FAIL sat_load got %0d exp 2", q_s); end
    enable = 1'b1; up_dn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (tc_s !== exp_tc[i]) begin errors++; $display("FAIL sat_tc[%0d] got %0b exp %0b", i, tc_s, exp_tc[i]); end
      tick();
      checks++; if (q_s !== 4'(exp_q[i])) begin errors++; $display("FAIL sat_q[%0d] got %0d exp %0d", i, q_s, exp_q[i]); end
      checks++; if (wrap_s !== 1'b0) begin errors++; $display("FAIL sat_wrap[%0d] got %0b exp 0", i, wrap_s); end
    end
    enable = 1'b0; up_dn = 1'b1;
  endtask

  task automatic test_load_clamp();
    load = 1'b1; load_val = 4'd13;
    tick();
    checks++; if (q_w !== 4'd9) begin errors++; $display("FAIL clamp_q got %0d exp 9", q_w); end
    clr = 1'b1; load = 1'b1; enable = 1'b1; up_dn = 1'b1; load_val = 4'd5;
    #1;
    checks++; if (tc_w !== 1'b1) begin errors++; $display("FAIL clr_tc_ungated got %0b exp 1", tc_w); end
    tick();
    checks++; if (q_w !== 4'd0) begin errors++; $display("FAIL clr_prio_q got %0d exp 0", q_w); end
    checks++; if (wrap_w !== 1'b0) begin errors++; $display("FAIL clr_prio_wrap got %0b exp 0", wrap_w); end
    clr = 1'b0;
    tick();
    checks++; if (q_w !== 4'd5) begin errors++; $display("FAIL load_vs_step_q got %0d exp 5", q_w); end
    load = 1'b0; enable = 1'b0;
  endtask

  task automatic test_prescale();
    logic pat   [10] = '{1, 1, 0, 1, 0, 1, 1, 1, 0, 1};
    int   exp_q [10] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2};
    clr = 1'b1;
    tick();
    clr = 1'b0; up_dn = 1'b1;
    checks++; if (q_p !== 4'd0) begin errors++; $display("FAIL pre_clr_q got %0d exp 0", q_p); end
    checks++; if (zero_p !== 1'b1) begin errors++; $display("FAIL pre_zero got %0b exp 1", zero_p); end
    for (int i = 0; i < 10; i++) begin
      enable = pat[i];
      #1;
      checks++; if (tc_p !== 1'b0) begin errors++; $display("FAIL pre_tc[%0d] got %0b exp 0", i, tc_p); end
      tick();
      checks++; if (q_p !== 4'(exp_q[i])) begin errors++; $display("FAIL pre_q[%0d] got %0d exp %0d", i, q_p, exp_q[i]); end
    end
    checks++; if (wrap_p !== 1'b0) begin errors++; $display("FAIL pre_wrap got %0b exp 0", wrap_p); end
    enable = 1'b0;
  endtask

  task automatic test_async_reset();
    load = 1'b1; load_val = 4'd9;
    tick();
    load = 1'b0; enable = 1'b1; up_dn = 1'b1;
    tick();
    enable = 1'b0;
    checks++; if (wrap_w !== 1'b1) begin errors++; $display("FAIL ar_wrap_set got %0b exp 1", wrap_w); end
    #2 rst = 1'b0;
    #1;
    checks++; if (wrap_w !== 1'b0) begin errors++; $display("FAIL ar_wrap_discard got %0b exp 0", wrap_w); end
    #2 rst = 1'b1;
    load = 1'b1; load_val = 4'd5;
    tick();
    load = 1'b0; enable = 1'b1;
    tick();
    enable = 1'b0;
    checks++; if (q_w !== 4'd6) begin errors++; $display("FAIL ar_pre_q got %0d exp 6", q_w); end
    #2 rst = 1'b0;
    #1;
    checks++; if (q_w !== 4'd0) begin errors++; $display("FAIL ar_async_q got %0d exp 0", q_w); end
    checks++; if (zero_w !== 1'b1) begin errors++; $display("FAIL ar_async_zero got %0b exp 1", zero_w); end
    checks++; if (q_p !== 4'd0) begin errors++; $display("FAIL ar_async_qp got %0d exp 0", q_p); end
    #2 rst = 1'b1;
    enable = 1'b1; up_dn = 1'b1;
    tick();
    checks++; if (q_w !== 4'd1) begin errors++; $display("FAIL ar_first_q got %0d exp 1", q_w); end
    tick();
    checks++; if (q_p !== 4'd0) begin errors++; $display("FAIL ar_pre_partial got %0d exp 0", q_p); end
    tick();
    checks++; if (q_p !== 4'd1) begin errors++; $display("FAIL ar_pre_step got %0d exp 1", q_p); end
    enable = 1'b0;
  endtask

  task automatic test_dir_flip();
    load = 1'b1; load_val = 4'd9;
    tick();
    load = 1'b0; enable = 1'b1; up_dn = 1'b0;
    #1;
    checks++; if (tc_w !== 1'b0) begin errors++; $display("FAIL flip_tc got %0b exp 0", tc_w); end
    tick();
    checks++; if (q_w !== 4'd8) begin errors++; $display("FAIL flip_q got %0d exp 8", q_w); end
    checks++; if (wrap_w !== 1'b0) begin errors++; $display("FAIL flip_wrap got %0b exp 0", wrap_w); end
    load = 1'b1; load_val = 4'd0; enable = 1'b0;
    tick();
    load = 1'b0; enable = 1'b1; up_dn = 1'b0;
    #1;
    checks++; if (tc_w !== 1'b1) begin errors++; $display("FAIL down_wrap_tc got %0b exp 1", tc_w); end
    tick();
    checks++; if (q_w !== 4'd9) begin errors++; $display("FAIL down_wrap_q got %0d exp 9", q_w); end
    checks++; if (wrap_w !== 1'b1) begin errors++; $display("FAIL down_wrap_pulse got %0b exp 1", wrap_w); end
    enable = 1'b0;
    tick();
    checks++; if (wrap_w !== 1'b0) begin errors++; $display("FAIL down_wrap_one_cycle got %0b exp 0", wrap_w); end
    checks++; if (q_w !== 4'd9) begin errors++; $display("FAIL down_wrap_hold got %0d exp 9", q_w); end
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; load = 1'b0; enable = 1'b0; up_dn = 1'b1; load_val = 4'd0;
    test_reset();
    test_up_wrap();
    test_down_sat();
    test_load_clamp();
    test_prescale();
    test_async_reset();
    test_dir_flip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_mod_updn.md
# counter_mod_updn

Parametrised up/down modulo counter: the successor to the team's fixed up-only enable counter, used for UART bit/baud counting, pipeline stall timers and cycle counters. It adds programmable modulus, direction control, synchronous clear and load, wrap-or-saturate mode, an enable prescaler, and terminal-count/wrap flags. It sits beside the TX/RX FSMs and is driven purely by their control strobes.

## Interface
- `N`, 8: counter width in bits.
- `MAX_VAL`, 2**N-1: terminal (highest) value. Legal range is 1..2**N-1.
- `SATURATE`, 0: 0 means wrap at the bounds; 1 means hold at the bounds.
- `PRESCALE`, 1: number of qualified `enable` cycles per count step. Legal range is 1..256.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-low reset. Asserted at 0.
- `clr` input 1: synchronous clear to 0. Also clears the prescaler.
- `load` input 1: synchronous load of `load_val`. Also clears the prescaler.
- `load_val` input N: load value. Values above `MAX_VAL` are clamped to `MAX_VAL`.
- `enable` input 1: count request for this cycle.
- `up_dn` input 1: direction. 1 counts up, 0 counts down.
- `Q` output N: registered count.
- `tc` output 1: combinational terminal-count flag.
- `wrap` output 1: registered one-cycle pulse.
- `zero` output 1: combinational, equals (`Q`==0).

## Operation
- **Control priority per cycle:** `clr` > `load` > step.
- **Step qualification:** a step occurs when `enable`=1 and the prescaler count equals `PRESCALE`-1.
  - The prescaler counts qualified `enable` cycles from 0 to `PRESCALE`-1, then returns to 0.
  - With `PRESCALE`=1 every `enable` cycle is a step, with no added latency.
- **Up step:**
  - If `Q`<`MAX_VAL`: `Q`+1.
  - If `Q`==`MAX_VAL`: becomes 0 when `SATURATE`=0; holds when `SATURATE`=1.
- **Down step:**
  - If `Q`>0: `Q`-1.
  - If `Q`==0: becomes `MAX_VAL` when `SATURATE`=0; holds when `SATURATE`=1.
- **`tc`:** high when `enable`=1, the prescaler is at its last count, and `Q` is at the bound in the current `up_dn` direction (`MAX_VAL` going up, 0 going down). `tc` is not gated by `clr` or `load`.
- **`wrap`:** registered. Set for exactly one cycle after a step that crossed a bound with `SATURATE`=0. It is never set when `SATURATE`=1.
- **Width rule:** all arithmetic is N bits wide. Bound comparisons use N-bit `MAX_VAL`. No intermediate carry is exposed.
- **`up_dn` changes:** a change in `up_dn` takes effect on the same cycle's step. No idle cycle is required.

## Timing
- **Reset:** while `rst`=0, regardless of `clk`:
  - `Q`=0, `wrap`=0, prescaler=0.
  - `zero`=1.
  - `tc`=0 unless `enable`=1, `up_dn`=0 and the prescaler is at its last count (always true when `PRESCALE`=1).
- **Reset release:** first possible step is on the first rising edge with `rst`=1.
- **Latency:**
  - `clr`, `load` and step are visible on `Q` one cycle after the edge.
  - `wrap` appears in the same cycle as the wrapped `Q`.
- **Simultaneous events:**
  - `clr` with `load`: `clr` wins.
  - `load` with `enable`: the load wins, no step is taken, and the prescaler resets.
  - `clr` with a step at a bound: `wrap` stays 0.
- **Reset mid-operation:** reset discards any partial prescale and any pending `wrap` pulse.

## Structure
- **Shared package `counter_pkg`:**
  - Mode constants `CNT_WRAP`=0 and `CNT_SAT`=1.
  - Direction constants `CNT_DOWN`=0 and `CNT_UP`=1.
  - Function `clamp_to_max`.
- **Sub-module `counter_prescaler`:**
  - Parameter: `PRESCALE`.
  - Ports: `clk`, `rst`, `restart`, `enable`, and output `step`.
  - Width is $clog2(`PRESCALE`), with a minimum of 1 bit.
  - For `PRESCALE`=1 it is generated away, and `step` equals `enable`.
- **Top level:** next-state mux, bound comparators, and the `wrap` flop.

## Test plan
- **Up wrap** (N=4, `MAX_VAL`=9, `SATURATE`=0): 12 `enable` cycles with `up_dn`=1 from reset.
  - `Q` runs 1..9, 0, 1, 2.
  - `tc` is high in the cycle where `Q`=9.
  - `wrap` pulses in the one cycle where `Q`=0.
- **Down saturate** (`SATURATE`=1, `MAX_VAL`=9): load 2, then 4 `enable` cycles with `up_dn`=0.
  - `Q` goes 1, 0, 0, 0.
  - `wrap` never asserts.
- **Load clamp and priority** (`MAX_VAL`=9):
  - `load_val`=13 with `load` → `Q`=9.
  - `clr`, `load` and `enable` together → `Q`=0.
  - `load`=1, `enable`=1, `load_val`=5 → `Q`=5, no step.
- **Prescale** (`PRESCALE`=3): 7 `enable` cycles going up.
  - `Q` steps only on qualified-enable cycles 3 and 6, ending at `Q`=2.
  - `enable` gaps do not advance the prescaler.
- **Async reset mid-count:** with `Q`=6, pull `rst` low between clock edges.
  - `Q`=0 immediately, before the next edge.
  - After release, the first `enable` gives `Q`=1.
- **Direction flip at bound** (`MAX_VAL`=9, `Q`=9): `up_dn`=0 with `enable`.
  - `Q`=8, `tc`=0, no `wrap`.
